tmds_decoder: RTL and testbench

- Receive-side counterpart of the DVI TMDS encoder: takes one 10-bit TMDS character per pixel clock from a per-channel deserialiser and recovers 8-bit colour, 2-bit control and data enable.
- Contains a word-alignment state machine that finds character boundaries from control-token runs in blanking, and requests a one-position bit slip from the deserialiser until lock.
- One instance per TMDS channel (R, G, B) in the DVI capture path.

---
 rtl/tmds_decoder_pkg.sv | 29 ++
 rtl/tmds_char_decode.sv | 52 +++++
 rtl/tmds_decoder.sv | 170 +++++++++++++++++
 tb/tb_tmds_decoder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_decoder_pkg.sv
// Shared TMDS definitions: character width, the four DVI control tokens,
// the word-alignment state type and a transition-count helper.
package tmds_decoder_pkg;

    localparam int TMDS_CHAR_W = 10;

    // Control tokens as they appear in the parallel word (bit 0 first on the wire).
    localparam logic [TMDS_CHAR_W-1:0] TOK_C0 = 10'b1101010100;  // {c1,c0} = 00
    localparam logic [TMDS_CHAR_W-1:0] TOK_C1 = 10'b0010101011;  // {c1,c0} = 01
    localparam logic [TMDS_CHAR_W-1:0] TOK_C2 = 10'b0101010100;  // {c1,c0} = 10
    localparam logic [TMDS_CHAR_W-1:0] TOK_C3 = 10'b1010101011;  // {c1,c0} = 11

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_e;

    // Number of set bits in the 9-entry adjacent-pair transition vector.
    function automatic logic [3:0] count_trans(input logic [TMDS_CHAR_W-2:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < TMDS_CHAR_W - 1; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_char_decode.sv
// Combinational decode of one 10-bit TMDS character.
//   word_i    : aligned TMDS character
//   is_ctrl_o : word is one of the four control tokens
//   ctrl_o    : {c1,c0} of the token (0 for data words)
//   data_o    : 8-bit data recovered from the word (meaningful for data words)
//   bad_o     : data word with too many transitions to be a legal encoding
module tmds_char_decode
    import tmds_decoder_pkg::*;
(
    input  logic [TMDS_CHAR_W-1:0] word_i,
    output logic                   is_ctrl_o,
    output logic [1:0]             ctrl_o,
    output logic [7:0]             data_o,
    output logic                   bad_o
);

    logic [7:0]             d;
    logic [TMDS_CHAR_W-2:0] trans;

    // Bit 9 flags that the encoder inverted the payload.
    assign d = word_i[9] ? ~word_i[7:0] : word_i[7:0];

    // Bit 8 selects whether the encoder chained with XOR (1) or XNOR (0).
    assign data_o[0] = d[0];
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_chain
            assign data_o[gi] = word_i[8] ? (d[gi] ^ d[gi-1]) : ~(d[gi] ^ d[gi-1]);
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < TMDS_CHAR_W - 1; gi++) begin : g_trans
            assign trans[gi] = word_i[gi+1] ^ word_i[gi];
        end
    endgenerate

    always_comb begin
        is_ctrl_o = 1'b1;
        ctrl_o    = 2'b00;
        case (word_i)
            TOK_C0:  ctrl_o = 2'b00;
            TOK_C1:  ctrl_o = 2'b01;
            TOK_C2:  ctrl_o = 2'b10;
            TOK_C3:  ctrl_o = 2'b11;
            default: is_ctrl_o = 1'b0;
        endcase
    end

    // Legal data characters are transition-minimised; 6+ transitions cannot occur.
    assign bad_o = !is_ctrl_o && (count_trans(trans) >= 4'd6);

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder with word alignment.
//   clk_pix  : pixel clock          rst_pix  : synchronous active-high reset
//   tmds     : parallel character from the deserialiser
//   bitslip  : one-cycle request to shift deserialiser alignment by one bit
//   locked   : word alignment established
//   dout     : decoded colour data   ctrl_out : decoded {c1,c0}
//   de       : data enable           code_err : illegal data character flag
// Two-stage pipeline: tmds -> w_q -> decoded outputs. Alignment FSM acts on w_q.
module tmds_decoder
    import tmds_decoder_pkg::*;
#(
    parameter int unsigned CTRL_RUN   = 8,
    parameter int unsigned SEARCH_LEN = 4096,
    parameter int unsigned SLIP_WAIT  = 16
) (
    input  logic                   clk_pix,
    input  logic                   rst_pix,
    input  logic [TMDS_CHAR_W-1:0] tmds,
    output logic                   bitslip,
    output logic                   locked,
    output logic [7:0]             dout,
    output logic [1:0]             ctrl_out,
    output logic                   de,
    output logic                   code_err
);

    localparam int unsigned CYC_MAX = (SEARCH_LEN > SLIP_WAIT) ? SEARCH_LEN : SLIP_WAIT;
    localparam int CYC_W = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int RUN_W = $clog2(CTRL_RUN + 1);

    logic [TMDS_CHAR_W-1:0] w_q;
    logic                   dec_is_ctrl;
    logic [1:0]             dec_ctrl;
    logic [7:0]             dec_data;
    logic                   dec_bad;

    logic [7:0] dout_q, dout_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic       de_q, de_d;
    logic       err_q, err_d;

    align_state_e state_q;
    logic [RUN_W-1:0] run_q, run_inc;
    logic [CYC_W-1:0] cyc_q;
    logic             locked_q;
    logic             bitslip_q;
    logic             qual;
    logic             search_done;
    logic             slip_done;

    tmds_char_decode u_dec (
        .word_i    (w_q),
        .is_ctrl_o (dec_is_ctrl),
        .ctrl_o    (dec_ctrl),
        .data_o    (dec_data),
        .bad_o     (dec_bad)
    );

    // Output stage: data is gated by the alignment state of the same cycle,
    // control bits decode regardless of lock and hold across data words.
    always_comb begin
        dout_d = '0;
        de_d   = 1'b0;
        err_d  = 1'b0;
        ctrl_d = ctrl_q;
        if (dec_is_ctrl) begin
            ctrl_d = dec_ctrl;
        end else if (locked_q) begin
            dout_d = dec_data;
            de_d   = 1'b1;
            err_d  = dec_bad;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            w_q    <= '0;
            dout_q <= '0;
            ctrl_q <= '0;
            de_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            w_q    <= tmds;
            dout_q <= dout_d;
            ctrl_q <= ctrl_d;
            de_q   <= de_d;
            err_q  <= err_d;
        end
    end

    // Saturating token-run count; any data word breaks the run.
    always_comb begin
        run_inc = '0;
        if (dec_is_ctrl) begin
            run_inc = (run_q == RUN_W'(CTRL_RUN)) ? run_q : run_q + RUN_W'(1);
        end
    end

    // Qualifies only on the cycle the run first reaches CTRL_RUN, never while slipping.
    assign qual        = dec_is_ctrl && (run_q == RUN_W'(CTRL_RUN - 1)) && (state_q != ST_SLIP);
    assign search_done = (cyc_q == CYC_W'(SEARCH_LEN - 1));
    assign slip_done   = (cyc_q == CYC_W'(SLIP_WAIT - 1));

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q   <= ST_SEARCH;
            run_q     <= '0;
            cyc_q     <= '0;
            locked_q  <= 1'b0;
            bitslip_q <= 1'b0;
        end else begin
            bitslip_q <= 1'b0;
            case (state_q)
                ST_SEARCH: begin
                    if (qual) begin
                        // Lock takes priority over a timeout on the same cycle.
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                        cyc_q    <= '0;
                        run_q    <= run_inc;
                    end else if (search_done) begin
                        state_q   <= ST_SLIP;
                        bitslip_q <= 1'b1;
                        cyc_q     <= '0;
                        run_q     <= '0;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                        run_q <= run_inc;
                    end
                end
                ST_SLIP: begin
                    // Deserialiser is settling: input is meaningless here.
                    run_q <= '0;
                    if (slip_done) begin
                        state_q <= ST_SEARCH;
                        cyc_q   <= '0;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                ST_LOCKED: begin
                    run_q <= run_inc;
                    if (qual) begin
                        cyc_q <= '0;
                    end else if (search_done) begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                        cyc_q    <= '0;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                default: begin
                    state_q  <= ST_SEARCH;
                    locked_q <= 1'b0;
                    cyc_q    <= '0;
                    run_q    <= '0;
                end
            endcase
        end
    end

    assign bitslip  = bitslip_q;
    assign locked   = locked_q;
    assign dout     = dout_q;
    assign ctrl_out = ctrl_q;
    assign de       = de_q;
    assign code_err = err_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder with a cycle-level reference model
// built from the decoding and alignment rules using timestamps.
module tb_tmds_decoder;

    localparam int CTRL_RUN   = 8;
    localparam int SEARCH_LEN = 64;
    localparam int SLIP_WAIT  = 4;

    localparam logic [9:0] T0 = 10'b1101010100;
    localparam logic [9:0] T1 = 10'b0010101011;
    localparam logic [9:0] T2 = 10'b0101010100;
    localparam logic [9:0] T3 = 10'b1010101011;

    logic       clk_pix = 1'b0;
    logic       rst_pix = 1'b1;
    logic [9:0] tmds    = '0;
    logic       bitslip, locked, de, code_err;
    logic [7:0] dout;
    logic [1:0] ctrl_out;

    tmds_decoder #(
        .CTRL_RUN   (CTRL_RUN),
        .SEARCH_LEN (SEARCH_LEN),
        .SLIP_WAIT  (SLIP_WAIT)
    ) dut (
        .clk_pix  (clk_pix),
        .rst_pix  (rst_pix),
        .tmds     (tmds),
        .bitslip  (bitslip),
        .locked   (locked),
        .dout     (dout),
        .ctrl_out (ctrl_out),
        .de       (de),
        .code_err (code_err)
    );

    always #5 clk_pix = ~clk_pix;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state. mode: 0 search, 1 slip, 2 locked.
    logic [9:0] m_w;
    int         m_mode, m_since, m_cyc, m_run;
    logic       e_lock, e_slip, e_de, e_err;
    logic [7:0] e_dout;
    logic [1:0] e_ctrl;

    // Observation counters since the last reset.
    int steps, slip_count, first_slip, second_slip, de_count, lock_count, err_count;
    int enc_disp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (step %0d)", tag, obs, exp, steps);
        end
    endtask

    function automatic int tok_code(input logic [9:0] w);
        case (w)
            T0:      return 0;
            T1:      return 1;
            T2:      return 2;
            T3:      return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] ref_data(input logic [9:0] w);
        logic [7:0] d, r;
        d = w[9] ? ~w[7:0] : w[7:0];
        r[0] = d[0];
        for (int i = 1; i < 8; i++) r[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return r;
    endfunction

    function automatic int n_trans(input logic [9:0] w);
        int n = 0;
        for (int i = 0; i < 9; i++) if (w[i] != w[i+1]) n++;
        return n;
    endfunction

    // DVI transmitter encoding with running disparity.
    function automatic logic [9:0] tmds_enc(input logic [7:0] dv);
        int n1, n1q, n0q;
        logic [8:0] qm;
        logic [9:0] q;
        logic xn;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(dv[i]);
        xn = (n1 > 4) || (n1 == 4 && dv[0] == 1'b0);
        qm[0] = dv[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ dv[i]) : (qm[i-1] ^ dv[i]);
        qm[8] = ~xn;
        n1q = 0;
        for (int i = 0; i < 8; i++) n1q += int'(qm[i]);
        n0q = 8 - n1q;
        if (enc_disp == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            if (qm[8]) enc_disp += n1q - n0q; else enc_disp += n0q - n1q;
        end else if ((enc_disp > 0 && n1q > n0q) || (enc_disp < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            enc_disp += 2 * int'(qm[8]) + n0q - n1q;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            enc_disp += -2 * int'(!qm[8]) + n1q - n0q;
        end
        return q;
    endfunction

    task automatic model_reset();
        m_w = '0; m_mode = 0; m_since = 0; m_cyc = 0; m_run = 0;
        e_lock = 0; e_slip = 0; e_de = 0; e_err = 0; e_dout = '0; e_ctrl = '0;
    endtask

    // Expected outputs after one clock edge with input a.
    task automatic model_edge(input logic [9:0] a);
        int  code, el;
        bit  tok, qual;
        code = tok_code(m_w);
        tok  = (code >= 0);
        if (tok) begin
            e_ctrl = 2'(code); e_dout = '0; e_de = 0; e_err = 0;
        end else begin
            e_de   = e_lock;
            e_dout = e_lock ? ref_data(m_w) : 8'h00;
            e_err  = e_lock && (n_trans(m_w) >= 6);
        end
        e_slip = 0;
        el = m_cyc - m_since;
        if (m_mode == 1) begin
            m_run = 0;
            if (el == SLIP_WAIT - 1) begin m_mode = 0; m_since = m_cyc + 1; end
        end else begin
            m_run = tok ? m_run + 1 : 0;
            qual  = (m_run == CTRL_RUN);
            if (m_mode == 0) begin
                if (qual) begin
                    m_mode = 2; m_since = m_cyc + 1;
                end else if (el == SEARCH_LEN - 1) begin
                    m_mode = 1; m_since = m_cyc + 1; e_slip = 1; m_run = 0;
                end
            end else begin
                if (qual) m_since = m_cyc + 1;
                else if (el == SEARCH_LEN - 1) begin m_mode = 0; m_since = m_cyc + 1; end
            end
        end
        e_lock = (m_mode == 2);
        m_w = a;
        m_cyc++;
    endtask

    task automatic compare_all();
        check("locked",   32'(locked),   32'(e_lock));
        check("bitslip",  32'(bitslip),  32'(e_slip));
        check("de",       32'(de),       32'(e_de));
        check("dout",     32'(dout),     32'(e_dout));
        check("ctrl_out", 32'(ctrl_out), 32'(e_ctrl));
        check("code_err", 32'(code_err), 32'(e_err));
    endtask

    task automatic step(input logic [9:0] a);
        model_edge(a);
        tmds = a;
        @(posedge clk_pix);
        #1;
        steps++;
        compare_all();
        if (bitslip === 1'b1) begin
            slip_count++;
            if (first_slip < 0) first_slip = steps;
            else if (second_slip < 0) second_slip = steps;
        end
        if (de === 1'b1) de_count++;
        if (locked === 1'b1) lock_count++;
        if (code_err === 1'b1) err_count++;
        $display("step %0d tmds=%03h locked=%b bitslip=%b de=%b dout=%02h ctrl=%b err=%b",
                 steps, a, locked, bitslip, de, dout, ctrl_out, code_err);
    endtask

    task automatic do_reset(input int n);
        rst_pix = 1'b1;
        for (int i = 0; i < n; i++) begin
            tmds = 10'($urandom);
            @(posedge clk_pix);
            #1;
            model_reset();
            compare_all();
            $display("reset cycle %0d tmds=%03h bitslip=%b locked=%b", i, tmds, bitslip, locked);
        end
        rst_pix = 1'b0;
        steps = 0; slip_count = 0; first_slip = -1; second_slip = -1;
        de_count = 0; lock_count = 0; err_count = 0;
    endtask

    initial begin
        int v;
        // Reset with random input.
        do_reset(3);

        // Lock on 8 tokens: locked rises the cycle after the 8th token is in w.
        repeat (8) step(T0);
        check("lock_before", 32'(locked), 32'd0);
        step(T0);
        check("lock_after", 32'(locked), 32'd1);
        check("lock_ctrl", 32'(ctrl_out), 32'd0);
        check("lock_de", 32'(de), 32'd0);

        // Two directed data words.
        step(10'h100);
        step(10'h200);
        check("d100_dout", 32'(dout), 32'h00);
        check("d100_de", 32'(de), 32'd1);
        step(T0);
        check("d200_dout", 32'(dout), 32'hFF);
        check("d200_ctrl", 32'(ctrl_out), 32'd0);
        step(T0);
        check("d_tok_de", 32'(de), 32'd0);

        // Encoder round trip of all byte values, refreshing lock between chunks.
        err_count = 0;
        for (int c = 0; c < 8; c++) begin
            enc_disp = 0;
            for (int t = 0; t < 8; t++) begin
                step(T0);
                if (c > 0 && t == 0) check("enc_last", 32'(dout), 32'(c * 32 - 1));
            end
            for (int j = 0; j < 32; j++) begin
                v = c * 32 + j;
                step(tmds_enc(8'(v)));
                if (j > 0) begin
                    check("enc_dout", 32'(dout), 32'(v - 1));
                    check("enc_de", 32'(de), 32'd1);
                end
            end
        end
        step(T0);
        check("enc_final", 32'(dout), 32'hFF);
        check("enc_errs", 32'(err_count), 32'd0);

        // Illegal data character while locked.
        step(10'b0101010101);
        step(T1);
        check("err_flag", 32'(code_err), 32'd1);
        check("err_de", 32'(de), 32'd1);
        check("err_dout", 32'(dout), 32'hFF);
        step(T1);
        check("err_clear", 32'(code_err), 32'd0);
        check("err_ctrl", 32'(ctrl_out), 32'd1);

        // Loss of lock on data only, recovery on tokens without a slip.
        repeat (9) step(T0);
        slip_count = 0;
        repeat (66) step(10'h100);
        check("loss_locked", 32'(locked), 32'd0);
        repeat (9) step(T2);
        check("recover_locked", 32'(locked), 32'd1);
        check("recover_slips", 32'(slip_count), 32'd0);

        // Search/slip cadence with no tokens at all.
        do_reset(3);
        repeat (140) step(10'h100);
        check("slip_first", 32'(first_slip), 32'd64);
        check("slip_second", 32'(second_slip), 32'd132);
        check("slip_count", 32'(slip_count), 32'd2);
        check("slip_de", 32'(de_count), 32'd0);
        check("slip_lock", 32'(lock_count), 32'd0);

        // Reset in the middle of SLIP.
        do_reset(1);
        repeat (65) step(10'h100);
        check("mid_slip_seen", 32'(first_slip), 32'd64);
        do_reset(1);
        check("rst_slip_bitslip", 32'(bitslip), 32'd0);
        check("rst_slip_locked", 32'(locked), 32'd0);
        repeat (64) step(10'h100);
        check("rst_slip_restart", 32'(first_slip), 32'd64);

        // Qualifying run ending on the last SEARCH cycle wins over the slip.
        do_reset(1);
        repeat (55) step(10'h100);
        repeat (8) step(T3);
        step(T3);
        check("bound_locked", 32'(locked), 32'd1);
        check("bound_bitslip", 32'(bitslip), 32'd0);
        check("bound_slips", 32'(slip_count), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            v = int'($urandom_range(0, 9));
            case (v)
                0, 1, 2: step(T0);
                3:       step(($urandom_range(0, 1) == 0) ? T1 : T2);
                4, 5:    step(tmds_enc(8'($urandom)));
                default: step(10'($urandom));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
